fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter bits, default 32, SHALL set address width.
REQ-002 Parameter isize, default 2, SHALL set log2 of instruction width in bytes; instruction width SHALL be 8<<isize bits.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ip_addr  in  bits  current instruction pointer value.
REQ-006 ip_incr  out  1  advance instruction pointer by one instruction.
REQ-007 ip_jmp  out  1  load instruction pointer from ip_jaddr.
REQ-008 ip_jaddr  out  bits  jump target.
REQ-009 mem_req  out  1  instruction memory read request.
REQ-010 mem_addr  out  bits  request address.
REQ-011 mem_ack  in  1  memory response valid; completes request.
REQ-012 mem_rdata  in  8<<isize  fetched instruction.
REQ-013 redirect  in  1  branch/exception redirect strobe.
REQ-014 redirect_addr  in  bits  redirect target.
REQ-015 inst_valid  out  1  instruction available to decode.
REQ-016 inst_ready  in  1  decode accepts instruction.
REQ-017 inst_data  out  8<<isize  held instruction.
REQ-018 inst_addr  out  bits  address of held instruction.

Function
REQ-019 States SHALL be IDLE, REQ, HOLD, DRAIN; IDLE SHALL move to REQ unconditionally after one cycle.
REQ-020 REQ: mem_req=1, mem_addr=ip_addr; mem_req SHALL stay high with mem_addr stable until mem_ack; one outstanding request max.
REQ-021 REQ with mem_ack, no redirect: latch inst_data=mem_rdata, inst_addr=mem_addr; ip_incr=1 same cycle; next state HOLD.
REQ-022 HOLD: inst_valid=1, inst_data/inst_addr stable; inst_ready -> REQ next cycle, inst_valid=0 next cycle.
REQ-023 Redirect in any non-IDLE state SHALL assert ip_jmp=1, ip_jaddr=redirect_addr that cycle, and force ip_incr=0.
REQ-024 Redirect in HOLD (with or without inst_ready) SHALL discard the held instruction and go to REQ; inst_valid=0 next cycle.
REQ-025 Redirect in REQ with same-cycle mem_ack SHALL discard mem_rdata and go to REQ.
REQ-026 Redirect in REQ without mem_ack SHALL capture mem_addr into drain_addr and go to DRAIN.
REQ-027 DRAIN: mem_req=1, mem_addr=drain_addr, inst_valid=0; mem_ack discards data and goes to REQ; redirect in DRAIN SHALL re-jump and remain in DRAIN unless mem_ack same cycle (then REQ).
REQ-028 ip_incr and ip_jmp SHALL never both be 1; both SHALL be 0 in IDLE.
REQ-029 mem_ack outside REQ/DRAIN SHALL be ignored.
REQ-030 ip_jaddr SHALL equal redirect_addr whenever ip_jmp=1; otherwise it SHALL be 0.

Reset
REQ-031 rst SHALL force state IDLE, mem_req=0, inst_valid=0, ip_incr=0, ip_jmp=0, inst_data=0, inst_addr=0, drain_addr=0 on the next edge.
REQ-032 rst mid-request SHALL drop mem_req next cycle without waiting for mem_ack; the memory aborts the request.
REQ-033 rst SHALL take priority over redirect and mem_ack in the same cycle.

Configuration
REQ-034 With FETCH_SEQ_FLUSH_COUNT_EN defined: output flush_count (16 bits), reset 0, +1 per redirect per REQ-024..027, saturating at 0xFFFF.
REQ-035 Without FETCH_SEQ_FLUSH_COUNT_EN: flush_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-036 rst 1 cycle, ip_addr=0x0, mem_ack one cycle after mem_req with 0x00000013 -> mem_addr=0x0, ip_incr pulse at ack, inst_valid=1, inst_data=0x00000013, inst_addr=0x0.
REQ-037 inst_ready=0 for 5 cycles in HOLD -> inst_valid held, data stable, mem_req=0; inst_ready=1 -> REQ next cycle at ip_addr=0x4.
REQ-038 Redirect to 0x100 in REQ with mem_ack delayed 3 cycles -> ip_jmp pulse, DRAIN with mem_addr=old address until ack, data dropped, next mem_addr=0x100.
REQ-039 Redirect to 0x200 coincident with mem_ack -> ip_jmp=1, ip_incr=0, inst_valid stays 0, next mem_addr=0x200.
REQ-040 rst asserted while mem_req=1 -> mem_req=0 and inst_valid=0 next cycle, state IDLE; late mem_ack ignored.
REQ-041 With FETCH_SEQ_FLUSH_COUNT_EN: 3 discarding redirects -> flush_count=3; preloaded 0xFFFF stays 0xFFFF.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory read, a single held instruction for decode,
// and redirect handling. Define FETCH_SEQ_FLUSH_COUNT_EN to add the saturating flush_count output.
module fetch_sequencer #(
    parameter int bits  = 32,
    parameter int isize = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [bits-1:0]          ip_addr,
    output logic                     ip_incr,
    output logic                     ip_jmp,
    output logic [bits-1:0]          ip_jaddr,
    output logic                     mem_req,
    output logic [bits-1:0]          mem_addr,
    input  logic                     mem_ack,
    input  logic [(8<<isize)-1:0]    mem_rdata,
    input  logic                     redirect,
    input  logic [bits-1:0]          redirect_addr,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [(8<<isize)-1:0]    inst_data,
    output logic [bits-1:0]          inst_addr
`ifdef FETCH_SEQ_FLUSH_COUNT_EN
    ,
    output logic [15:0]              flush_count
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t          state;
    state_t          state_nx;
    logic [bits-1:0] drain_addr;
    logic            capture;
    logic            drain_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            inst_data  <= '0;
            inst_addr  <= '0;
            drain_addr <= '0;
        end else begin
            state <= state_nx;
            if (capture) begin
                inst_data <= mem_rdata;
                inst_addr <= mem_addr;
            end
            if (drain_load) begin
                drain_addr <= mem_addr;
            end
        end
    end

    // Reset masks the IP strobes so a same-cycle redirect or ack cannot leak out.
    always_comb begin
        state_nx   = state;
        ip_incr    = 1'b0;
        ip_jmp     = 1'b0;
        ip_jaddr   = '0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        inst_valid = 1'b0;
        capture    = 1'b0;
        drain_load = 1'b0;

        if (state != IDLE && redirect && !rst) begin
            ip_jmp   = 1'b1;
            ip_jaddr = redirect_addr;
        end

        case (state)
            IDLE: begin
                state_nx = REQ;
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = ip_addr;
                if (mem_ack && !redirect) begin
                    capture  = 1'b1;
                    ip_incr  = ~rst;
                    state_nx = HOLD;
                end else if (mem_ack) begin
                    state_nx = REQ;
                end else if (redirect) begin
                    // The memory still owes us a response for the old address; track it.
                    drain_load = 1'b1;
                    state_nx   = DRAIN;
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                if (redirect || inst_ready) begin
                    state_nx = REQ;
                end
            end
            DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = drain_addr;
                if (mem_ack) begin
                    state_nx = REQ;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef FETCH_SEQ_FLUSH_COUNT_EN
    // Every redirect outside IDLE discards in-flight or held work.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_count <= '0;
        end else if (ip_jmp && flush_count != 16'hFFFF) begin
            flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand sequences for
// redirect/flush corners, and randomized traffic against a transaction-level model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ip_addr = '0;
    logic        ip_incr;
    logic        ip_jmp;
    logic [31:0] ip_jaddr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_addr;
`ifdef FETCH_SEQ_FLUSH_COUNT_EN
    logic [15:0] flush_count;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(.bits(32), .isize(2)) dut (
        .clk(clk), .rst(rst), .ip_addr(ip_addr), .ip_incr(ip_incr), .ip_jmp(ip_jmp),
        .ip_jaddr(ip_jaddr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .redirect(redirect), .redirect_addr(redirect_addr),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_addr(inst_addr)
`ifdef FETCH_SEQ_FLUSH_COUNT_EN
        , .flush_count(flush_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: a fetch is either wanted (result goes to decode) or discarded, at most one
    // instruction is held, and the bench owns the instruction pointer.
    bit          m_known, m_started, m_held, m_discard;
    logic [31:0] m_ip, m_drain, m_data, m_iaddr;
`ifdef FETCH_SEQ_FLUSH_COUNT_EN
    logic [15:0] m_flush;
`endif
    bit          e_req, e_valid, e_incr, e_jmp;
    logic [31:0] e_addr, e_jaddr;

    task automatic checkOutput();
        cmp("mem_req", mem_req, e_req);
        cmp("mem_addr", mem_addr, e_addr);
        cmp("inst_valid", inst_valid, e_valid);
        cmp("ip_incr", ip_incr, e_incr);
        cmp("ip_jmp", ip_jmp, e_jmp);
        cmp("ip_jaddr", ip_jaddr, e_jaddr);
        cmp("inst_data", inst_data, m_data);
        cmp("inst_addr", inst_addr, m_iaddr);
        cmp("incr_jmp_excl", ip_incr & ip_jmp, 0);
`ifdef FETCH_SEQ_FLUSH_COUNT_EN
        cmp("flush_count", flush_count, m_flush);
`endif
    endtask

    task automatic applyStimulus(input bit r, input bit rd, input logic [31:0] ra,
                                 input bit ak, input logic [31:0] rdat, input bit rdy);
        bit fetching;
        rst = r; redirect = rd; redirect_addr = ra; mem_ack = ak;
        mem_rdata = rdat; inst_ready = rdy; ip_addr = m_ip;
        #2;
        fetching = m_started && !m_held;
        e_req    = fetching;
        e_addr   = !fetching ? 32'h0 : (m_discard ? m_drain : m_ip);
        e_valid  = m_held;
        e_jmp    = !r && m_started && rd;
        e_jaddr  = e_jmp ? ra : 32'h0;
        e_incr   = !r && fetching && !m_discard && ak && !rd;
        if (m_known) checkOutput();
        @(posedge clk);
        #1;
        if (r) begin
            m_known = 1; m_started = 0; m_held = 0; m_discard = 0;
            m_drain = 0; m_data = 0; m_iaddr = 0;
`ifdef FETCH_SEQ_FLUSH_COUNT_EN
            m_flush = 0;
`endif
        end else if (!m_started) begin
            m_started = 1;
        end else begin
`ifdef FETCH_SEQ_FLUSH_COUNT_EN
            if (rd && m_flush != 16'hFFFF) m_flush = m_flush + 1;
`endif
            if (m_held) begin
                if (rd || rdy) m_held = 0;
            end else if (ak) begin
                if (!m_discard && !rd) begin
                    m_held = 1; m_data = rdat; m_iaddr = m_ip;
                end
                m_discard = 0;
            end else if (rd && !m_discard) begin
                m_discard = 1; m_drain = m_ip;
            end
            if (e_jmp) m_ip = ra;
            else if (e_incr) m_ip = m_ip + 4;
        end
    endtask

    typedef struct {
        bit          rst, redir;
        logic [31:0] raddr;
        bit          ack;
        logic [31:0] rdata;
        bit          ready;
        logic [31:0] ip;
        bit          chk, e_req;
        logic [31:0] e_addr;
        bit          e_valid, e_incr, e_jmp;
        logic [31:0] e_jaddr, e_data, e_iaddr;
    } vec_t;

    localparam int NV = 19;
    vec_t vec[NV];

    initial begin
        vec[0]  = '{1,0,0,0,0,0, 0, 0, 0,0,0,0,0,0,0,0};
        vec[1]  = '{0,0,0,0,0,0, 0, 1, 0,0,0,0,0,0,0,0};
        vec[2]  = '{0,0,0,0,0,0, 0, 1, 1,0,0,0,0,0,0,0};
        vec[3]  = '{0,0,0,1,32'h13,0, 0, 1, 1,0,0,1,0,0,0,0};
        for (int i = 4; i <= 8; i++)
            vec[i] = '{0,0,0,0,0,0, 4, 1, 0,0,1,0,0,0,32'h13,0};
        vec[9]  = '{0,0,0,0,0,1, 4, 1, 0,0,1,0,0,0,32'h13,0};
        vec[10] = '{0,1,32'h100,0,0,0, 4, 1, 1,4,0,0,1,32'h100,32'h13,0};
        vec[11] = '{0,0,0,0,0,0, 32'h100, 1, 1,4,0,0,0,0,32'h13,0};
        vec[12] = '{0,0,0,0,0,0, 32'h100, 1, 1,4,0,0,0,0,32'h13,0};
        vec[13] = '{0,0,0,1,32'hdead,0, 32'h100, 1, 1,4,0,0,0,0,32'h13,0};
        vec[14] = '{0,1,32'h200,1,32'hbeef,0, 32'h100, 1, 1,32'h100,0,0,1,32'h200,32'h13,0};
        vec[15] = '{0,0,0,0,0,0, 32'h200, 1, 1,32'h200,0,0,0,0,32'h13,0};
        vec[16] = '{1,1,32'h300,1,32'h55,0, 32'h200, 1, 1,32'h200,0,0,0,0,32'h13,0};
        vec[17] = '{0,0,0,1,32'h77,0, 32'h200, 1, 0,0,0,0,0,0,0,0};
        vec[18] = '{0,0,0,0,0,0, 32'h200, 1, 1,32'h200,0,0,0,0,0,0};

        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            rst = vec[i].rst; redirect = vec[i].redir; redirect_addr = vec[i].raddr;
            mem_ack = vec[i].ack; mem_rdata = vec[i].rdata; inst_ready = vec[i].ready;
            ip_addr = vec[i].ip;
            #2;
            if (vec[i].chk) begin
                cmp($sformatf("v%0d_mem_req", i), mem_req, vec[i].e_req);
                cmp($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].e_addr);
                cmp($sformatf("v%0d_inst_valid", i), inst_valid, vec[i].e_valid);
                cmp($sformatf("v%0d_ip_incr", i), ip_incr, vec[i].e_incr);
                cmp($sformatf("v%0d_ip_jmp", i), ip_jmp, vec[i].e_jmp);
                cmp($sformatf("v%0d_ip_jaddr", i), ip_jaddr, vec[i].e_jaddr);
                cmp($sformatf("v%0d_inst_data", i), inst_data, vec[i].e_data);
                cmp($sformatf("v%0d_inst_addr", i), inst_addr, vec[i].e_iaddr);
            end
            @(posedge clk);
            #1;
        end

        // Redirect while holding with inst_ready also high: held word is dropped.
        m_ip = 0;
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'habcd, 0);
        applyStimulus(0, 1, 32'h340, 0, 0, 1);
        ip_addr = m_ip;
        #1;
        cmp("hold_redir_valid", inst_valid, 0);
        cmp("hold_redir_req", mem_req, 1);
        cmp("hold_redir_addr", mem_addr, 32'h340);

`ifdef FETCH_SEQ_FLUSH_COUNT_EN
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h40, 0, 0, 0);
        applyStimulus(0, 1, 32'h80, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h1, 0);
        applyStimulus(0, 0, 0, 1, 32'h2, 0);
        applyStimulus(0, 1, 32'hc0, 0, 0, 0);
        cmp("flush_three", flush_count, 3);
`endif

        for (int n = 0; n < 2000; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 99) < 15),
                          $urandom() & 32'h0000_FFFC,
                          ($urandom_range(0, 99) < 40),
                          $urandom(),
                          ($urandom_range(0, 1) == 1));
        end

`ifdef FETCH_SEQ_FLUSH_COUNT_EN
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 65545; n++) applyStimulus(0, 1, 32'h800, 0, 0, 0);
        cmp("flush_sat", flush_count, 16'hFFFF);
        applyStimulus(0, 1, 32'h900, 0, 0, 0);
        cmp("flush_sat_hold", flush_count, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
